// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exc_ctrl
// Brief    : MEM-stage exception controller in front of the CP0 register
//            file. Arbitrates interrupts / synchronous exceptions against
//            MTC0 writes, owns the CP0 write port, sequences EPC and Status
//            updates, then flushes the pipeline and redirects the PC.
// Options  : CP0_EXC_COUNT_EN adds a saturating exception counter output.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR      = 32'h0000_0020,
  parameter logic [4:0]  CP0_EPC_ADDR    = 5'd14,
  parameter logic [4:0]  CP0_STATUS_ADDR = 5'd12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_inst_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_slot_i,
  input  logic [31:0] mem_excepttype_i,
  input  logic        mem_cp0_we_i,
  input  logic [4:0]  mem_cp0_waddr_i,
  input  logic [31:0] mem_cp0_data_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] excepttype_o,
  output logic [4:0]  exc_code_o,
  output logic        exc_bd_o
`ifdef CP0_EXC_COUNT_EN
  ,
  output logic [31:0] exc_count_o
`endif
);

  localparam logic [4:0] CP0_CAUSE_ADDR = 5'd13;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WR_EPC    = 2'd1;
  localparam logic [1:0] S_WR_STATUS = 2'd2;
  localparam logic [1:0] S_REDIRECT  = 2'd3;

  localparam logic [31:0] TYPE_NONE = 32'h0;
  localparam logic [31:0] TYPE_INT  = 32'h1;
  localparam logic [31:0] TYPE_SYS  = 32'h8;
  localparam logic [31:0] TYPE_RI   = 32'ha;
  localparam logic [31:0] TYPE_OV   = 32'hc;
  localparam logic [31:0] TYPE_TRAP = 32'hd;
  localparam logic [31:0] TYPE_ERET = 32'he;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;
  localparam logic [4:0] CODE_TRAP = 5'h0d;
  localparam logic [4:0] CODE_NONE = 5'h00;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] status_eff;
  logic [7:0]  cause_ip;
  logic        int_pending;
  logic [31:0] det_type;
  logic [4:0]  det_code;
  logic        take;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] type_q;
  logic [4:0]  code_q;
  logic        is_eret;
  logic        unused_bits;

  // Forward an in-flight MTC0 to Status so the interrupt check sees the new value
  always_comb begin
    status_eff = cp0_status_i;
    if (mem_cp0_we_i && (mem_cp0_waddr_i == CP0_STATUS_ADDR)) begin
      status_eff = mem_cp0_data_i;
    end
  end

  // Forward an in-flight MTC0 to Cause; only the software IP bits are writable
  always_comb begin
    cause_ip = cp0_cause_i[15:8];
    if (mem_cp0_we_i && (mem_cp0_waddr_i == CP0_CAUSE_ADDR)) begin
      cause_ip[1:0] = mem_cp0_data_i[9:8];
    end
  end

  // IE set, EXL clear, and at least one unmasked pending line
  assign int_pending = status_eff[0] & ~status_eff[1] & (|(cause_ip & status_eff[15:8]));

  // Fixed-priority pick of the exception to take this cycle
  always_comb begin
    det_type = TYPE_NONE;
    det_code = CODE_NONE;
    if (int_pending) begin
      det_type = TYPE_INT;
      det_code = CODE_INT;
    end else if (mem_excepttype_i[9]) begin
      det_type = TYPE_RI;
      det_code = CODE_RI;
    end else if (mem_excepttype_i[8]) begin
      det_type = TYPE_SYS;
      det_code = CODE_SYS;
    end else if (mem_excepttype_i[10]) begin
      det_type = TYPE_TRAP;
      det_code = CODE_TRAP;
    end else if (mem_excepttype_i[11]) begin
      det_type = TYPE_OV;
      det_code = CODE_OV;
    end else if (mem_excepttype_i[12]) begin
      det_type = TYPE_ERET;
      det_code = CODE_NONE;
    end
  end

  assign take    = (state == S_IDLE) && mem_inst_valid_i && (det_type != TYPE_NONE);
  assign is_eret = (type_q == TYPE_ERET);

  // Bits that the arbitration never looks at
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cp0_cause_i[31:16],
                         cp0_cause_i[7:0], mem_excepttype_i[31:13], mem_excepttype_i[7:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ERET skips the EPC write
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_next = (det_type == TYPE_ERET) ? S_WR_STATUS : S_WR_EPC;
        end
      end
      S_WR_EPC:    state_next = S_WR_STATUS;
      S_WR_STATUS: state_next = S_REDIRECT;
      S_REDIRECT:  state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Capture the faulting instruction context at the moment it is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= 32'h0;
      bd_q   <= 1'b0;
      type_q <= TYPE_NONE;
      code_q <= CODE_NONE;
    end else if (take) begin
      pc_q   <= mem_pc_i;
      bd_q   <= mem_in_delay_slot_i;
      type_q <= det_type;
      code_q <= det_code;
    end
  end

  // Output decode; reset forces every output low even though IDLE passes MTC0 through
  always_comb begin
    cp0_we_o    = 1'b0;
    cp0_waddr_o = 5'd0;
    cp0_data_o  = 32'h0;
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    new_pc_o    = 32'h0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (take) begin
            stall_o = 1'b1;
          end else begin
            cp0_we_o    = mem_cp0_we_i;
            cp0_waddr_o = mem_cp0_waddr_i;
            cp0_data_o  = mem_cp0_data_i;
          end
        end
        S_WR_EPC: begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = CP0_EPC_ADDR;
          cp0_data_o  = bd_q ? (pc_q - 32'd4) : pc_q;
          stall_o     = 1'b1;
        end
        S_WR_STATUS: begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = CP0_STATUS_ADDR;
          cp0_data_o  = is_eret ? (cp0_status_i & ~32'h2) : (cp0_status_i | 32'h2);
          stall_o     = 1'b1;
        end
        S_REDIRECT: begin
          flush_o  = 1'b1;
          new_pc_o = is_eret ? cp0_epc_i : EXC_VECTOR;
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
    end
  end

  assign excepttype_o = type_q;
  assign exc_code_o   = code_q;
  assign exc_bd_o     = bd_q;

`ifdef CP0_EXC_COUNT_EN
  // Count completed non-ERET exception entries, saturating at all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_count_o <= 32'h0;
    end else if ((state == S_REDIRECT) && !is_eret && (exc_count_o != 32'hFFFF_FFFF)) begin
      exc_count_o <= exc_count_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exc_ctrl
// Brief    : Self-checking bench for cp0_exc_ctrl. Directed scenarios followed
//            by randomized traffic compared against an action-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_inst_valid_i = 1'b0;
  logic [31:0] mem_pc_i = 32'h0;
  logic        mem_in_delay_slot_i = 1'b0;
  logic [31:0] mem_excepttype_i = 32'h0;
  logic        mem_cp0_we_i = 1'b0;
  logic [4:0]  mem_cp0_waddr_i = 5'd0;
  logic [31:0] mem_cp0_data_i = 32'h0;
  logic [31:0] cp0_status_i = 32'h0;
  logic [31:0] cp0_cause_i = 32'h0;
  logic [31:0] cp0_epc_i = 32'h0;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] excepttype_o;
  logic [4:0]  exc_code_o;
  logic        exc_bd_o;
`ifdef CP0_EXC_COUNT_EN
  logic [31:0] exc_count_o;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: pending CP0 actions of the current exception sequence
  localparam int A_EPC = 0, A_ST_SET = 1, A_ST_CLR = 2, A_JMP_VEC = 3, A_JMP_EPC = 4;
  int          act_q[$];
  logic [31:0] m_pc, m_type, m_count;
  logic        m_bd;
  logic [4:0]  m_code;

  cp0_exc_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_inst_valid_i    (mem_inst_valid_i),
    .mem_pc_i            (mem_pc_i),
    .mem_in_delay_slot_i (mem_in_delay_slot_i),
    .mem_excepttype_i    (mem_excepttype_i),
    .mem_cp0_we_i        (mem_cp0_we_i),
    .mem_cp0_waddr_i     (mem_cp0_waddr_i),
    .mem_cp0_data_i      (mem_cp0_data_i),
    .cp0_status_i        (cp0_status_i),
    .cp0_cause_i         (cp0_cause_i),
    .cp0_epc_i           (cp0_epc_i),
    .cp0_we_o            (cp0_we_o),
    .cp0_waddr_o         (cp0_waddr_o),
    .cp0_data_o          (cp0_data_o),
    .stall_o             (stall_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .excepttype_o        (excepttype_o),
    .exc_code_o          (exc_code_o),
    .exc_bd_o            (exc_bd_o)
`ifdef CP0_EXC_COUNT_EN
    ,
    .exc_count_o         (exc_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    act_q.delete();
    m_pc = 32'h0; m_type = 32'h0; m_bd = 1'b0; m_code = 5'h0; m_count = 32'h0;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic bd,
                        input logic [31:0] exc, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [31:0] st,
                        input logic [31:0] ca, input logic [31:0] epc);
    mem_inst_valid_i = v; mem_pc_i = pc; mem_in_delay_slot_i = bd;
    mem_excepttype_i = exc; mem_cp0_we_i = we; mem_cp0_waddr_i = wa;
    mem_cp0_data_i = wd; cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = epc;
  endtask

  task automatic idle_in();
    mem_inst_valid_i = 1'b0; mem_excepttype_i = 32'h0; mem_cp0_we_i = 1'b0;
  endtask

  task automatic rand_in();
    mem_inst_valid_i    = ($urandom_range(0, 3) != 0);
    mem_pc_i            = $urandom;
    mem_in_delay_slot_i = 1'($urandom_range(0, 1));
    mem_excepttype_i    = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom & 32'h0000_1F00);
    mem_cp0_we_i        = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: mem_cp0_waddr_i = 5'd12;
      1: mem_cp0_waddr_i = 5'd13;
      2: mem_cp0_waddr_i = 5'd14;
      default: mem_cp0_waddr_i = 5'($urandom);
    endcase
    mem_cp0_data_i = $urandom;
    cp0_status_i   = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      cp0_status_i[0] = 1'b1;
      cp0_status_i[1] = 1'b0;
    end
    cp0_cause_i = $urandom;
    if ($urandom_range(0, 2) != 0) cp0_cause_i[15:8] = 8'h0;
    cp0_epc_i = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs on the falling edge against the model, then advance the model
  task automatic sample();
    logic e_we, e_stall, e_flush, busy, intr;
    logic [4:0]  e_addr, c;
    logic [31:0] e_data, e_npc, s, t;
    logic [7:0]  ip;
    int a;
    @(negedge clk);
    e_we = 1'b0; e_addr = 5'd0; e_data = 32'h0; e_stall = 1'b0; e_flush = 1'b0; e_npc = 32'h0;
    t = 32'h0; c = 5'h0; a = -1;
    busy = (act_q.size() != 0);
    if (!busy) begin
      s = cp0_status_i;
      if (mem_cp0_we_i && mem_cp0_waddr_i == 5'd12) s = mem_cp0_data_i;
      ip = cp0_cause_i[15:8];
      if (mem_cp0_we_i && mem_cp0_waddr_i == 5'd13) ip[1:0] = mem_cp0_data_i[9:8];
      intr = s[0] && !s[1] && ((ip & s[15:8]) != 8'h0);
      if (mem_inst_valid_i) begin
        if (intr)                     begin t = 32'h1; c = 5'h00; end
        else if (mem_excepttype_i[9])  begin t = 32'ha; c = 5'h0a; end
        else if (mem_excepttype_i[8])  begin t = 32'h8; c = 5'h08; end
        else if (mem_excepttype_i[10]) begin t = 32'hd; c = 5'h0d; end
        else if (mem_excepttype_i[11]) begin t = 32'hc; c = 5'h0c; end
        else if (mem_excepttype_i[12]) begin t = 32'he; c = 5'h00; end
      end
      if (t != 32'h0) e_stall = 1'b1;
      else begin
        e_we = mem_cp0_we_i; e_addr = mem_cp0_waddr_i; e_data = mem_cp0_data_i;
      end
    end else begin
      a = act_q[0];
      case (a)
        A_EPC:     begin e_we = 1'b1; e_addr = 5'd14; e_data = m_bd ? m_pc - 32'd4 : m_pc; e_stall = 1'b1; end
        A_ST_SET:  begin e_we = 1'b1; e_addr = 5'd12; e_data = cp0_status_i | 32'h2; e_stall = 1'b1; end
        A_ST_CLR:  begin e_we = 1'b1; e_addr = 5'd12; e_data = cp0_status_i & ~32'h2; e_stall = 1'b1; end
        A_JMP_VEC: begin e_flush = 1'b1; e_npc = 32'h20; end
        default:   begin e_flush = 1'b1; e_npc = cp0_epc_i; end
      endcase
    end
    chk("cp0_we", 32'(cp0_we_o), 32'(e_we));
    chk("cp0_waddr", 32'(cp0_waddr_o), 32'(e_addr));
    chk("cp0_data", cp0_data_o, e_data);
    chk("stall", 32'(stall_o), 32'(e_stall));
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("new_pc", new_pc_o, e_npc);
    chk("excepttype", excepttype_o, m_type);
    chk("exc_code", 32'(exc_code_o), 32'(m_code));
    chk("exc_bd", 32'(exc_bd_o), 32'(m_bd));
`ifdef CP0_EXC_COUNT_EN
    chk("exc_count", exc_count_o, m_count);
`endif
    if (busy) begin
      if (a == A_JMP_VEC && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
      void'(act_q.pop_front());
    end else if (t != 32'h0) begin
      m_pc = mem_pc_i; m_bd = mem_in_delay_slot_i; m_type = t; m_code = c;
      if (t == 32'he) begin
        act_q.push_back(A_ST_CLR); act_q.push_back(A_JMP_EPC);
      end else begin
        act_q.push_back(A_EPC); act_q.push_back(A_ST_SET); act_q.push_back(A_JMP_VEC);
      end
    end
  endtask

  // Asynchronous reset pulse: outputs must clear without waiting for a clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_we", 32'(cp0_we_o), 32'h0);
    chk("rst_data", cp0_data_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_new_pc", new_pc_o, 32'h0);
    chk("rst_type", excepttype_o, 32'h0);
    chk("rst_code", 32'(exc_code_o), 32'h0);
    chk("rst_bd", 32'(exc_bd_o), 32'h0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Syscall at 0x100, not in a delay slot
    set_in(1'b1, 32'h100, 1'b0, 32'h100, 1'b0, 5'd0, 32'h0, 32'h1000_0001, 32'h0, 32'h0);
    sample(); chk("sys_stall", 32'(stall_o), 32'h1); tick();
    idle_in();
    sample(); chk("sys_epc_addr", 32'(cp0_waddr_o), 32'd14); chk("sys_epc_data", cp0_data_o, 32'h100); tick();
    sample(); chk("sys_st_data", cp0_data_o, 32'h1000_0003); tick();
    sample(); chk("sys_flush", 32'(flush_o), 32'h1); chk("sys_pc", new_pc_o, 32'h20);
    chk("sys_code", 32'(exc_code_o), 32'h08); tick();
    sample(); tick();

    // Overflow in a delay slot: EPC points at the branch
    set_in(1'b1, 32'h204, 1'b1, 32'h800, 1'b0, 5'd0, 32'h0, 32'h1000_0001, 32'h0, 32'h0);
    sample(); tick();
    idle_in();
    sample(); chk("ov_epc_data", cp0_data_o, 32'h200); chk("ov_bd", 32'(exc_bd_o), 32'h1);
    chk("ov_type", excepttype_o, 32'hc); tick();
    sample(); tick();
    sample(); tick();

    // Interrupt beats a concurrent syscall
    set_in(1'b1, 32'h400, 1'b0, 32'h100, 1'b0, 5'd0, 32'h0, 32'h401, 32'h400, 32'h0);
    sample(); chk("int_stall", 32'(stall_o), 32'h1); tick();
    idle_in();
    sample(); chk("int_code", 32'(exc_code_o), 32'h0); chk("int_type", excepttype_o, 32'h1); tick();
    sample(); chk("int_st_data", cp0_data_o, 32'h403); tick();
    sample(); chk("int_pc", new_pc_o, 32'h20); tick();

    // ERET: Status only, then jump to EPC
    set_in(1'b1, 32'h500, 1'b0, 32'h1000, 1'b0, 5'd0, 32'h0, 32'h3, 32'h0, 32'h300);
    sample(); tick();
    idle_in();
    sample(); chk("eret_addr", 32'(cp0_waddr_o), 32'd12); chk("eret_st_data", cp0_data_o, 32'h1); tick();
    sample(); chk("eret_flush", 32'(flush_o), 32'h1); chk("eret_pc", new_pc_o, 32'h300);
    chk("eret_we", 32'(cp0_we_o), 32'h0); tick();

    // MTC0 Status with an invalid slot passes through untouched
    set_in(1'b0, 32'h600, 1'b0, 32'h0, 1'b1, 5'd12, 32'h401, 32'h0, 32'h400, 32'h0);
    sample(); chk("mtc0_we", 32'(cp0_we_o), 32'h1); chk("mtc0_data", cp0_data_o, 32'h401); tick();
    // Same MTC0 on a valid instruction enables a pending interrupt via forwarding
    mem_inst_valid_i = 1'b1;
    sample(); chk("fwd_stall", 32'(stall_o), 32'h1); tick();
    idle_in();
    sample(); chk("fwd_type", excepttype_o, 32'h1); tick();
    sample(); tick();
    sample(); tick();

    // Reset while the EPC write is on the port
    set_in(1'b1, 32'h100, 1'b0, 32'h100, 1'b0, 5'd0, 32'h0, 32'h1000_0001, 32'h0, 32'h0);
    sample(); tick();
    chk("pre_rst_epc_we", 32'(cp0_we_o), 32'h1);
    do_reset();
    idle_in();
    sample(); chk("post_rst_no_st", 32'(cp0_we_o), 32'h0); tick();
    set_in(1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    sample(); chk("post_rst_mtc0_addr", 32'(cp0_waddr_o), 32'd3);
    chk("post_rst_mtc0_data", cp0_data_o, 32'hDEAD_BEEF); tick();

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      rand_in();
      sample();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
